fc_layer_sequencer: RTL and testbench

Controller that runs one fully connected layer (FC1, FC2 or FC3) of the LeNet-5 inference path. It sequences the shared FC weight RAM (synchronous read, 1-cycle latency) and FC bias RAM (asynchronous read) together with the activation buffer, and performs signed int8×int8 multiply-accumulate per output neuron. It writes one 32-bit result per neuron to the downstream output buffer. It sits between the top-level inference FSM, which issues `start`/`layer_sel`, and the FC weight/bias storage.

---
 rtl/fc_seq_pkg.sv | 66 ++++++
 rtl/fc_mac_unit.sv | 51 +++++
 rtl/fc_layer_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_seq_pkg.sv
// ---------------------------------------------------------------------------
// fc_seq_pkg : layer encodings, per-layer geometry and FSM states for the
//              LeNet-5 fully connected layer sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fc_seq_pkg;

  localparam int FC_ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    LAYER_FC1 = 2'd0,
    LAYER_FC2 = 2'd1,
    LAYER_FC3 = 2'd2,
    LAYER_INV = 2'd3
  } fc_layer_e;

  localparam int FC1_IN    = 400;
  localparam int FC1_OUT   = 120;
  localparam int FC1_WBASE = 0;
  localparam int FC1_BBASE = 0;

  localparam int FC2_IN    = 120;
  localparam int FC2_OUT   = 84;
  localparam int FC2_WBASE = 48000;
  localparam int FC2_BBASE = 120;

  localparam int FC3_IN    = 84;
  localparam int FC3_OUT   = 10;
  localparam int FC3_WBASE = 58080;
  localparam int FC3_BBASE = 204;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } fc_state_e;

  typedef struct packed {
    logic [8:0]  n_in;
    logic [6:0]  n_out;
    logic [15:0] wbase;
    logic [7:0]  bbase;
  } fc_layer_cfg_t;

  // Unknown selections fall back to FC1; the caller filters LAYER_INV first.
  function automatic fc_layer_cfg_t fc_layer_cfg(input logic [1:0] sel);
    fc_layer_cfg_t c;
    case (fc_layer_e'(sel))
      LAYER_FC2: c = '{n_in: 9'(FC2_IN), n_out: 7'(FC2_OUT),
                       wbase: 16'(FC2_WBASE), bbase: 8'(FC2_BBASE)};
      LAYER_FC3: c = '{n_in: 9'(FC3_IN), n_out: 7'(FC3_OUT),
                       wbase: 16'(FC3_WBASE), bbase: 8'(FC3_BBASE)};
      default:   c = '{n_in: 9'(FC1_IN), n_out: 7'(FC1_OUT),
                       wbase: 16'(FC1_WBASE), bbase: 8'(FC1_BBASE)};
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fc_mac_unit.sv
// ---------------------------------------------------------------------------
// fc_mac_unit : signed 8x8 multiply with one-cycle read-valid pipe and a
//               bias-loadable wrapping accumulator.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fc_mac_unit
  import fc_seq_pkg::*;
#(
  parameter int ACC_W = FC_ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_issue,
  input  logic                    i_load_bias,
  input  logic                    i_acc_en,
  input  logic signed [7:0]       i_weight,
  input  logic signed [7:0]       i_act,
  input  logic signed [ACC_W-1:0] i_bias,
  output logic signed [ACC_W-1:0] o_acc
);

  logic                    r_rd_valid;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [15:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext;

  assign w_prod     = $signed({{8{i_weight[7]}}, i_weight}) * $signed({{8{i_act[7]}}, i_act});
  assign w_prod_ext = {{(ACC_W-16){w_prod[15]}}, w_prod};

  // RAM data arrives one cycle after issue, so the pipe bit marks that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_rd_valid <= i_issue;
      if (i_load_bias) begin
        r_acc <= i_bias;
      end else if (r_rd_valid && i_acc_en) begin
        r_acc <= r_acc + w_prod_ext;
      end
    end
  end

  assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/fc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// fc_layer_sequencer : runs one LeNet-5 FC layer over weight/bias/activation
//                      storage. Optional ReLU on FC1/FC2: FC_SEQ_RELU_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fc_layer_sequencer
  import fc_seq_pkg::*;
#(
  parameter int ACC_W   = FC_ACC_W_DEF,
  parameter int WADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              layer_sel,
  output logic                    busy,
  output logic                    done,
  output logic [WADDR_W-1:0]      w_rd_addr,
  input  logic signed [7:0]       w_rd_data,
  output logic [7:0]              b_rd_addr,
  input  logic signed [ACC_W-1:0] b_rd_data,
  output logic [8:0]              act_rd_addr,
  input  logic signed [7:0]       act_rd_data,
  output logic                    out_valid,
  output logic [6:0]              out_idx,
  output logic signed [ACC_W-1:0] out_data
);

  fc_state_e               r_state;
  fc_state_e               w_state_nxt;

  logic [WADDR_W-1:0]      r_w_rd_addr;
  logic [7:0]              r_b_rd_addr;
  logic [8:0]              r_act_rd_addr;
  logic [8:0]              r_last_i;
  logic [6:0]              r_last_n;
  logic [6:0]              r_n;

  fc_layer_cfg_t           w_cfg;
  logic                    w_accept;
  logic                    w_last_i;
  logic                    w_last_n;
  logic                    w_issue;
  logic                    w_load_bias;
  logic signed [ACC_W-1:0] w_acc;

  assign w_cfg    = fc_layer_cfg(layer_sel);
  assign w_accept = (r_state == ST_IDLE) && start && (layer_sel != LAYER_INV);
  assign w_last_i = (r_act_rd_addr == r_last_i);
  assign w_last_n = (r_n == r_last_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_load_bias = 1'b0;
    busy        = (r_state != ST_IDLE);
    done        = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_BIAS;
      end
      ST_BIAS: begin
        w_load_bias = 1'b1;
        w_state_nxt = ST_MAC;
      end
      ST_MAC: begin
        w_issue = 1'b1;
        if (w_last_i) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        out_valid   = 1'b1;
        w_state_nxt = w_last_n ? ST_DONE : ST_BIAS;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // The weight address simply runs on: after the last input of neuron n it
  // already equals wbase + (n+1)*in, the first weight of the next neuron.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_rd_addr   <= '0;
      r_b_rd_addr   <= '0;
      r_act_rd_addr <= '0;
      r_last_i      <= '0;
      r_last_n      <= '0;
      r_n           <= '0;
    end else begin
      if (w_accept) begin
        r_w_rd_addr   <= WADDR_W'(w_cfg.wbase);
        r_b_rd_addr   <= w_cfg.bbase;
        r_act_rd_addr <= '0;
        r_last_i      <= w_cfg.n_in - 9'd1;
        r_last_n      <= w_cfg.n_out - 7'd1;
        r_n           <= '0;
      end else if (r_state == ST_MAC) begin
        r_w_rd_addr   <= r_w_rd_addr + WADDR_W'(1);
        r_act_rd_addr <= w_last_i ? 9'd0 : r_act_rd_addr + 9'd1;
      end else if ((r_state == ST_WRITE) && !w_last_n) begin
        r_n           <= r_n + 7'd1;
        r_b_rd_addr   <= r_b_rd_addr + 8'd1;
      end
    end
  end

  fc_mac_unit #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .i_issue     (w_issue),
    .i_load_bias (w_load_bias),
    .i_acc_en    (busy),
    .i_weight    (w_rd_data),
    .i_act       (act_rd_data),
    .i_bias      (b_rd_data),
    .o_acc       (w_acc)
  );

  assign w_rd_addr   = r_w_rd_addr;
  assign b_rd_addr   = r_b_rd_addr;
  assign act_rd_addr = r_act_rd_addr;
  assign out_idx     = r_n;

`ifdef FC_SEQ_RELU_EN
  logic r_relu_ok;

  // FC3 produces logits, so only the hidden layers are rectified.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_relu_ok <= 1'b0;
    end else if (w_accept) begin
      r_relu_ok <= (layer_sel != LAYER_FC3);
    end
  end

  assign out_data = (r_relu_ok && w_acc[ACC_W-1]) ? '0 : w_acc;
`else
  assign out_data = w_acc;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fc_layer_sequencer : directed self-checking bench for fc_layer_sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fc_layer_sequencer;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [1:0]         layer_sel;
  logic               busy;
  logic               done;
  logic [15:0]        w_rd_addr;
  logic signed [7:0]  w_rd_data;
  logic [7:0]         b_rd_addr;
  logic signed [31:0] b_rd_data;
  logic [8:0]         act_rd_addr;
  logic signed [7:0]  act_rd_data;
  logic               out_valid;
  logic [6:0]         out_idx;
  logic signed [31:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Stimulus-side run context.
  int mode      = 0;
  int t0        = 0;
  int exp_base  = 0;
  int exp_inc   = 0;
  int exp_first = 0;
  int chk_fc1   = 0;
  int wr_base   = 0;
  int done_base = 0;

  // Monitor-side running totals.
  int   wr_total   = 0;
  int   done_total = 0;
  int   done_cyc   = -1;
  logic prev_valid = 1'b0;

  fc_layer_sequencer #(
    .ACC_W   (32),
    .WADDR_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .layer_sel   (layer_sel),
    .busy        (busy),
    .done        (done),
    .w_rd_addr   (w_rd_addr),
    .w_rd_data   (w_rd_data),
    .b_rd_addr   (b_rd_addr),
    .b_rd_data   (b_rd_data),
    .act_rd_addr (act_rd_addr),
    .act_rd_data (act_rd_data),
    .out_valid   (out_valid),
    .out_idx     (out_idx),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Storage models: mode 0 = ones with bias k on FC3, 1 = -128/127/0, 2 = ones/0.
  always @(posedge clk) begin
    w_rd_data   <= (mode == 1) ? -8'sd128 : 8'sd1;
    act_rd_data <= (mode == 1) ? 8'sd127 : 8'sd1;
  end
  always_comb b_rd_data = (mode == 0) ? ($signed({24'd0, b_rd_addr}) - 32'sd204) : 32'sd0;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (rst !== 1'b1) begin
      if (out_valid === 1'b1) begin
        check_eq("out_idx", out_idx, wr_total - wr_base);
        check_eq("out_data", out_data, exp_base + exp_inc * (wr_total - wr_base));
        check_eq("out_b2b", prev_valid, 0);
        if (wr_total == wr_base) check_eq("first_wr_cyc", rel, exp_first);
        wr_total++;
      end
      if (done === 1'b1) begin
        done_total++;
        done_cyc = rel;
      end
      if (chk_fc1 != 0 && rel == 47958) check_eq("fc1_b_addr_last_bias", b_rd_addr, 119);
      if (chk_fc1 != 0 && rel == 48358) begin
        check_eq("fc1_w_addr_last", w_rd_addr, 47999);
        check_eq("fc1_act_addr_last", act_rd_addr, 399);
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic start_layer(input logic [1:0] sel);
    @(posedge clk); #1;
    wr_base   = wr_total;
    done_base = done_total;
    start     = 1'b1;
    layer_sel = sel;
    t0        = cyc;
    @(posedge clk); #1;
    start     = 1'b0;
    layer_sel = 2'd0;
  endtask

  task automatic finish_run(input string nm, input int budget, input int exp_done,
                            input int exp_wr);
    int n = 0;
    while (done_total == done_base && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq({nm, "_done_count"}, done_total - done_base, 1);
    check_eq({nm, "_done_cycle"}, done_cyc, exp_done);
    check_eq({nm, "_writes"}, wr_total - wr_base, exp_wr);
    check_eq({nm, "_busy_after"}, busy, 0);
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    layer_sel = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_w_addr", w_rd_addr, 0);
    check_eq("rst_b_addr", b_rd_addr, 0);
    check_eq("rst_act_addr", act_rd_addr, 0);
    rst = 1'b0;

    // Invalid layer select is ignored.
    start_layer(2'd3);
    check_eq("inv_busy_c1", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    check_eq("inv_busy_later", busy, 0);
    check_eq("inv_no_done", done_total - done_base, 0);

    // FC3: outputs 84 + k, done at 871.
    mode = 0; exp_base = 84; exp_inc = 1; exp_first = 87;
    start_layer(2'd2);
    check_eq("fc3_busy_c1", busy, 1);
    check_eq("fc3_b_addr_c1", b_rd_addr, 204);
    finish_run("fc3", 1200, 871, 10);

    // FC3 with a second start while busy.
    start_layer(2'd2);
    repeat (50) @(posedge clk);
    #1;
    start = 1'b1; layer_sel = 2'd1;
    @(posedge clk); #1;
    start = 1'b0; layer_sel = 2'd0;
    finish_run("fc3_restart", 1200, 871, 10);

    // FC2 full run: -128 * 127 * 120.
    mode = 1; exp_inc = 0; exp_first = 123;
`ifdef FC_SEQ_RELU_EN
    exp_base = 0;
`else
    exp_base = -1950720;
`endif
    start_layer(2'd1);
    finish_run("fc2", 12000, 10333, 84);

    // FC2 interrupted by reset at cycle 200.
    start_layer(2'd1);
    repeat (199) @(posedge clk);
    #1;
    check_eq("fc2_rst_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("fc2_rst_busy", busy, 0);
    check_eq("fc2_rst_out_valid", out_valid, 0);
    check_eq("fc2_rst_w_addr", w_rd_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("fc2_rst_no_done", done_total - done_base, 0);
    check_eq("fc2_rst_writes", wr_total - wr_base, 1);
    check_eq("fc2_rst_idle", busy, 0);

    // FC3 after reset.
    mode = 0; exp_base = 84; exp_inc = 1; exp_first = 87;
    start_layer(2'd2);
    finish_run("fc3_post_rst", 1200, 871, 10);

    // FC1 full run with address checks on the final neuron.
    mode = 2; exp_base = 400; exp_inc = 0; exp_first = 403; chk_fc1 = 1;
    start_layer(2'd0);
    finish_run("fc1", 50000, 48361, 120);
    chk_fc1 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
